// File: rtl/turbo_pkg.sv
// -----------------------------------------------------------------------------
// turbo_pkg
//   Shared constants and helpers for the LTE turbo interleaver blocks.
//   - IW                : index/address width (covers 0..6143)
//   - K_*/F1_*/F2_*     : QPP parameters of the two supported block sizes
//   - qpp_state_e       : FSM encoding of the QPP address generator
//   - qpp_k/qpp_g0/qpp_two_f2 : per-block-size constants selected by k
// -----------------------------------------------------------------------------
package turbo_pkg;

    localparam int IW = 14;

    localparam logic [IW-1:0] K_SMALL  = 14'd1056;
    localparam logic [IW-1:0] K_LARGE  = 14'd6144;
    localparam logic [IW-1:0] F1_SMALL = 14'd17;
    localparam logic [IW-1:0] F2_SMALL = 14'd66;
    localparam logic [IW-1:0] F1_LARGE = 14'd263;
    localparam logic [IW-1:0] F2_LARGE = 14'd480;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } qpp_state_e;

    // Block length for the given size select.
    function automatic logic [IW-1:0] qpp_k(input logic sel);
        return sel ? K_LARGE : K_SMALL;
    endfunction

    // g(0) = f1 + f2; always below K for both sizes, so no reduction needed.
    function automatic logic [IW-1:0] qpp_g0(input logic sel);
        return sel ? (F1_LARGE + F2_LARGE) : (F1_SMALL + F2_SMALL);
    endfunction

    // Constant second difference of the quadratic, 2*f2 (also below K).
    function automatic logic [IW-1:0] qpp_two_f2(input logic sel);
        return sel ? (F2_LARGE << 1) : (F2_SMALL << 1);
    endfunction

endpackage

// File: rtl/qpp_mod_add.sv
// -----------------------------------------------------------------------------
// qpp_mod_add
//   Combinational modular adder: y = (a + b) mod m.
//   Both operands must already be below m, so a single conditional subtract
//   brings the sum back into range.
//   Ports:
//     a, b  in  W   operands, each < m
//     m     in  W   modulus
//     y     out W   (a + b) mod m
// -----------------------------------------------------------------------------
module qpp_mod_add #(
    parameter int W = 14
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] m,
    output logic [W-1:0] y
);

    logic [W:0] sum;
    logic [W:0] sum_red;

    // One extra bit so the carry of a+b is kept for the compare.
    assign sum     = {1'b0, a} + {1'b0, b};
    assign sum_red = sum - {1'b0, m};
    assign y       = (sum >= {1'b0, m}) ? sum_red[W-1:0] : sum[W-1:0];

endmodule

// File: rtl/qpp_addr_gen.sv
// -----------------------------------------------------------------------------
// qpp_addr_gen
//   LTE QPP interleaver address generator. Takes the sequential index i from
//   the index counter and emits pi(i) = (f1*i + f2*i^2) mod K one clock later,
//   using the multiplier-free recursion
//     pi(i+1) = pi(i) + g(i),  g(i+1) = g(i) + 2*f2   (all mod K).
//   Ports:
//     clock      in   1   system clock
//     reset      in   1   async, active-high
//     k          in   1   block size: 0 -> K=1056, 1 -> K=6144 (latched at block start)
//     ready      in   1   block enable; low aborts the block and returns to IDLE
//     ind_in     in   IW  sequential index from the index counter
//     addr_out   out  IW  interleaved address, registered
//     addr_valid out  1   addr_out carries a new address this cycle
//     done       out  1   all K addresses emitted (level, until ready low)
//     err        out  1   sticky: index sequence broken
// -----------------------------------------------------------------------------
module qpp_addr_gen #(
    parameter int IW = 14
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          k,
    input  logic          ready,
    input  logic [IW-1:0] ind_in,
    output logic [IW-1:0] addr_out,
    output logic          addr_valid,
    output logic          done,
    output logic          err
);

    import turbo_pkg::*;

    localparam logic [IW-1:0] ONE = IW'(1);

    qpp_state_e    state_q, state_d;
    logic [IW-1:0] k_len_q, k_len_d;    // latched K for the current block
    logic [IW-1:0] two_f2_q, two_f2_d;  // latched 2*f2 for the current block
    logic [IW-1:0] pi_q, pi_d;          // pi of the next index to be emitted
    logic [IW-1:0] g_q, g_d;            // g of the next index to be emitted
    logic [IW-1:0] exp_q, exp_d;        // next index expected from the counter
    logic [IW-1:0] addr_q, addr_d;
    logic          valid_q, valid_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic [IW-1:0] pi_nxt;
    logic [IW-1:0] g_nxt;

    qpp_mod_add #(.W(IW)) u_pi_add (
        .a (pi_q),
        .b (g_q),
        .m (k_len_q),
        .y (pi_nxt)
    );

    qpp_mod_add #(.W(IW)) u_g_add (
        .a (g_q),
        .b (two_f2_q),
        .m (k_len_q),
        .y (g_nxt)
    );

    always_comb begin
        state_d  = state_q;
        k_len_d  = k_len_q;
        two_f2_d = two_f2_q;
        pi_d     = pi_q;
        g_d      = g_q;
        exp_d    = exp_q;
        addr_d   = addr_q;
        valid_d  = 1'b0;
        done_d   = done_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                addr_d = '0;
                done_d = 1'b0;
                err_d  = 1'b0;
                if (ready && (ind_in == '0)) begin
                    // pi(0) is always 0; preload the state for index 1.
                    k_len_d  = qpp_k(k);
                    two_f2_d = qpp_two_f2(k);
                    valid_d  = 1'b1;
                    pi_d     = qpp_g0(k);
                    g_d      = qpp_g0(k) + qpp_two_f2(k);
                    exp_d    = ONE;
                    state_d  = ST_RUN;
                end
            end

            ST_RUN: begin
                if (ind_in == exp_q) begin
                    addr_d  = pi_q;
                    valid_d = 1'b1;
                    pi_d    = pi_nxt;
                    g_d     = g_nxt;
                    exp_d   = exp_q + ONE;
                    if (exp_q == k_len_q - ONE) begin
                        // Last address goes out on this edge; done rises with it.
                        done_d  = 1'b1;
                        state_d = ST_DONE;
                    end
                end else if (ind_in != exp_q - ONE) begin
                    // Repeating the previous index is a counter stall, not an error.
                    err_d = 1'b1;
                end
            end

            ST_DONE: begin
                done_d = 1'b1;
                if (ind_in != k_len_q - ONE) begin
                    err_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping ready abandons the block from any state.
        if (!ready) begin
            state_d = ST_IDLE;
            pi_d    = '0;
            g_d     = '0;
            exp_d   = '0;
            addr_d  = '0;
            valid_d = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            k_len_q  <= K_SMALL;
            two_f2_q <= '0;
            pi_q     <= '0;
            g_q      <= '0;
            exp_q    <= '0;
            addr_q   <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_len_q  <= k_len_d;
            two_f2_q <= two_f2_d;
            pi_q     <= pi_d;
            g_q      <= g_d;
            exp_q    <= exp_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign addr_out   = addr_q;
    assign addr_valid = valid_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_qpp_addr_gen.sv
// -----------------------------------------------------------------------------
// tb_qpp_addr_gen
//   Self-checking bench for qpp_addr_gen: full blocks of both sizes against a
//   closed-form model, a hand-computed address table, and directed sequences
//   for abort, async reset, mid-block k change, counter stall and index jump.
// -----------------------------------------------------------------------------
module tb_qpp_addr_gen;

    localparam int IW = 14;

    logic          clock = 1'b0;
    logic          reset;
    logic          k;
    logic          ready;
    logic [IW-1:0] ind_in;
    logic [IW-1:0] addr_out;
    logic          addr_valid;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    qpp_addr_gen #(.IW(IW)) dut (
        .clock      (clock),
        .reset      (reset),
        .k          (k),
        .ready      (ready),
        .ind_in     (ind_in),
        .addr_out   (addr_out),
        .addr_valid (addr_valid),
        .done       (done),
        .err        (err)
    );

    typedef struct {
        bit kk;
        int idx;
        int addr;
    } vec_t;

    vec_t vecs[11];
    int   got0[1056];
    int   got1[6144];
    bit   seen[6144];

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Closed-form reference, independent of the recursive datapath.
    function automatic int model(input bit kk, input int i);
        longint kl = kk ? 64'd6144 : 64'd1056;
        longint f1 = kk ? 64'd263 : 64'd17;
        longint f2 = kk ? 64'd480 : 64'd66;
        longint li = longint'(i);
        return int'((f1 * li + f2 * li * li) % kl);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_cycle();
        ready  = 1'b0;
        ind_in = '0;
        tick();
    endtask

    // Run a full uninterrupted block; optionally flip k at index toggle_at.
    task automatic run_block(input bit kk, input int toggle_at,
                             output int nvalid, output int nbad);
        int kl;
        kl     = kk ? 6144 : 1056;
        k      = kk;
        ready  = 1'b1;
        nvalid = 0;
        nbad   = 0;
        for (int i = 0; i < kl; i++) begin
            if (i == toggle_at) k = ~kk;
            ind_in = IW'(i);
            tick();
            if (!addr_valid) begin
                nbad++;
            end else begin
                nvalid++;
                if (int'(addr_out) != model(kk, i)) nbad++;
                if (kk) begin
                    got1[i] = int'(addr_out);
                    seen[addr_out] = 1'b1;
                end else begin
                    got0[i] = int'(addr_out);
                end
            end
            if (err) nbad++;
            if (i == kl - 2 && done) nbad++;
        end
        // Counter parks at K-1 after the block.
        ind_in = IW'(kl - 1);
        tick();
        tick();
    endtask

    initial begin
        int nvalid;
        int nbad;
        int nseen;

        vecs[0]  = '{1'b0, 0,    0};
        vecs[1]  = '{1'b0, 1,    83};
        vecs[2]  = '{1'b0, 2,    298};
        vecs[3]  = '{1'b0, 3,    645};
        vecs[4]  = '{1'b0, 4,    68};
        vecs[5]  = '{1'b0, 1055, 49};
        vecs[6]  = '{1'b1, 0,    0};
        vecs[7]  = '{1'b1, 1,    743};
        vecs[8]  = '{1'b1, 2,    2446};
        vecs[9]  = '{1'b1, 3,    5109};
        vecs[10] = '{1'b1, 6143, 217};

        reset  = 1'b1;
        ready  = 1'b0;
        k      = 1'b0;
        ind_in = '0;
        #12;
        check("rst_addr",  addr_out,   0);
        check("rst_valid", addr_valid, 0);
        check("rst_done",  done,       0);
        check("rst_err",   err,        0);
        @(negedge clock);
        reset = 1'b0;
        idle_cycle();

        // Full K=1056 block
        run_block(1'b0, -1, nvalid, nbad);
        check("k0_valids", nvalid, 1056);
        check("k0_bad",    nbad,   0);
        check("k0_done",   done,   1);
        check("k0_dvalid", addr_valid, 0);
        check("k0_derr",   err,    0);
        idle_cycle();
        check("k0_done_clr", done, 0);

        // Full K=6144 block with permutation bitmap
        for (int i = 0; i < 6144; i++) seen[i] = 1'b0;
        run_block(1'b1, -1, nvalid, nbad);
        check("k1_valids", nvalid, 6144);
        check("k1_bad",    nbad,   0);
        check("k1_done",   done,   1);
        check("k1_derr",   err,    0);
        nseen = 0;
        for (int i = 0; i < 6144; i++) nseen += int'(seen[i]);
        check("k1_perm", nseen, 6144);
        idle_cycle();

        // Hand-computed address table
        for (int v = 0; v < 11; v++) begin
            check($sformatf("tbl_k%0d_i%0d", vecs[v].kk, vecs[v].idx),
                  vecs[v].kk ? got1[vecs[v].idx] : got0[vecs[v].idx], vecs[v].addr);
        end

        // k flips mid-block: block keeps K=1056, next block uses K=6144
        run_block(1'b0, 100, nvalid, nbad);
        check("ktog_valids", nvalid, 1056);
        check("ktog_bad",    nbad,   0);
        idle_cycle();
        k = 1'b1; ready = 1'b1; ind_in = '0; tick();
        ind_in = IW'(1); tick();
        check("ktog_next_addr", addr_out, 743);
        idle_cycle();

        // Abort at i=500 of a K=6144 block, then restart
        k = 1'b1; ready = 1'b1;
        for (int i = 0; i <= 500; i++) begin
            ind_in = IW'(i);
            tick();
        end
        check("ab_pre_addr", addr_out, model(1'b1, 500));
        ready = 1'b0; ind_in = '0;
        nbad = 0;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (addr_valid || done || err) nbad++;
        end
        check("ab_low_bad", nbad, 0);
        ready = 1'b1; ind_in = '0; tick();
        check("ab_re_valid", addr_valid, 1);
        check("ab_re_addr0", addr_out,   0);
        ind_in = IW'(1); tick();
        check("ab_re_addr1", addr_out, 743);
        idle_cycle();

        // Counter stall then index jump 10 -> 12
        k = 1'b0; ready = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            ind_in = IW'(i);
            tick();
        end
        ind_in = IW'(5); tick();
        check("hold_valid", addr_valid, 0);
        check("hold_err",   err,        0);
        ind_in = IW'(6); tick();
        check("hold_resume_v", addr_valid, 1);
        check("hold_resume_a", addr_out,   model(1'b0, 6));
        for (int i = 7; i <= 10; i++) begin
            ind_in = IW'(i);
            tick();
        end
        ind_in = IW'(12); tick();
        check("jump_err",   err,        1);
        check("jump_valid", addr_valid, 0);
        ind_in = IW'(13); tick();
        tick();
        check("jump_sticky", err,        1);
        check("jump_valid2", addr_valid, 0);
        idle_cycle();
        check("jump_clr", err, 0);

        // Async reset between edges in the middle of a block
        k = 1'b0; ready = 1'b1;
        for (int i = 0; i <= 20; i++) begin
            ind_in = IW'(i);
            tick();
        end
        check("ar_pre_addr", addr_out, model(1'b0, 20));
        #2;
        reset = 1'b1;
        #1;
        check("ar_addr",  addr_out,   0);
        check("ar_valid", addr_valid, 0);
        check("ar_done",  done,       0);
        check("ar_err",   err,        0);
        tick();
        reset = 1'b0;
        ind_in = IW'(21); tick();
        check("ar_idle_novalid", addr_valid, 0);
        check("ar_idle_noerr",   err,        0);
        ind_in = '0; tick();
        check("ar_restart_v", addr_valid, 1);
        check("ar_restart_a", addr_out,   0);
        ind_in = IW'(1); tick();
        check("ar_restart_a1", addr_out, 83);
        idle_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
